// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg : shared widths and segment patterns for the seconds display
// Revision 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);

  // bit0 = top ... bit5 = upper-left, bit6 = middle
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1100111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : BCD code to active-high segment pattern, with forced blank
// Revision 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import seven_seg_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_counter_mux.sv
// ============================================================================
// seven_segment_counter_mux : multi-digit BCD up/down seconds counter with a
// time-multiplexed seven-segment scan.  Revision 1.0
// ============================================================================
`default_nettype none

module seven_segment_counter_mux
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV     = 100,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_BLANK    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          up_down,
  input  logic                          clear,
  output logic [SEG_W-1:0]              led_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [BCD_W*NUM_DIGITS-1:0]   count_bcd,
  output logic                          wrap,
  output logic [SEG_W+NUM_DIGITS-1:0]   io_oeb
);

  localparam int PW = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

  localparam logic                  INV       = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_POL   = {SEG_W{INV}};
  localparam logic [NUM_DIGITS-1:0] SEL_POL   = {NUM_DIGITS{INV}};
  localparam logic [NUM_DIGITS-1:0] SEL_RESET = NUM_DIGITS'(1) ^ SEL_POL;

  logic [PW-1:0]         prescale;
  logic                  tick;
  logic [BCD_W-1:0]      digits      [NUM_DIGITS];
  logic [BCD_W-1:0]      digits_next [NUM_DIGITS];
  logic                  ripple_out;
  logic [RW-1:0]         refresh;
  logic                  refresh_done;
  logic [SW-1:0]         scan_idx;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [BCD_W-1:0]      shown_code;
  logic                  shown_blank;
  logic [SEG_W-1:0]      seg;

  assign tick   = enable && (prescale == PW'(CLK_DIV - 1));
  assign io_oeb = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (clear) begin
      prescale <= '0;
    end else if (enable) begin
      prescale <= tick ? '0 : prescale + PW'(1);
    end
  end

  // Carry/borrow ripples upward; surviving past the top digit means a wrap.
  always_comb begin
    logic ripple;
    ripple = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_next[i] = digits[i];
      if (ripple) begin
        if (up_down) begin
          if (digits[i] == DIGIT_MAX) begin
            digits_next[i] = '0;
          end else begin
            digits_next[i] = digits[i] + BCD_W'(1);
            ripple         = 1'b0;
          end
        end else begin
          if (digits[i] == '0) begin
            digits_next[i] = DIGIT_MAX;
          end else begin
            digits_next[i] = digits[i] - BCD_W'(1);
            ripple         = 1'b0;
          end
        end
      end
    end
    ripple_out = ripple;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
      end else if (tick) begin
        for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= digits_next[i];
        wrap <= ripple_out;
      end
    end
  end

  always_comb begin
    count_bcd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) count_bcd[i*BCD_W +: BCD_W] = digits[i];
  end

  assign refresh_done = (refresh == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh  <= '0;
      scan_idx <= '0;
    end else begin
      refresh <= refresh_done ? '0 : refresh + RW'(1);
      if (refresh_done) begin
        scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + SW'(1);
      end
    end
  end

  // A digit above 0 is blank when it and everything above it reads zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero   = higher_zero && (digits[i] == '0);
      blank_mask[i] = (LZ_BLANK != 0) && higher_zero;
    end
  end

  always_comb begin
    shown_code  = '0;
    shown_blank = 1'b0;
    sel_onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == SW'(i)) begin
        shown_code    = digits[i];
        shown_blank   = blank_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .code  (shown_code),
    .blank (shown_blank),
    .seg   (seg)
  );

  // Select and segments share one register stage so they never skew.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out   <= SEG_0 ^ SEG_POL;
      digit_sel <= SEL_RESET;
    end else begin
      led_out   <= seg ^ SEG_POL;
      digit_sel <= sel_onehot ^ SEL_POL;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_counter_mux.sv
// Bench: two instances (plain, and active-low with leading-zero blanking)
// share stimulus and are compared each cycle against an integer-level model.
`default_nettype none

module tb_seven_segment_counter_mux;

  localparam int CLK_DIV = 4;
  localparam int ND      = 2;
  localparam int RD      = 2;
  localparam int MODULO  = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic up_down = 1'b1;
  logic clear = 1'b0;

  logic [6:0]    a_led, b_led;
  logic [ND-1:0] a_sel, b_sel;
  logic [4*ND-1:0] a_count, b_count;
  logic          a_wrap, b_wrap;
  logic [6+ND:0] a_oeb, b_oeb;

  seven_segment_counter_mux #(
    .CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0), .LZ_BLANK(0)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .led_out(a_led), .digit_sel(a_sel), .count_bcd(a_count), .wrap(a_wrap), .io_oeb(a_oeb)
  );

  seven_segment_counter_mux #(
    .CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .LZ_BLANK(1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .led_out(b_led), .digit_sel(b_sel), .count_bcd(b_count), .wrap(b_wrap), .io_oeb(b_oeb)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int seg_tab [10] = '{32'h3f, 32'h06, 32'h5b, 32'h4f, 32'h66,
                       32'h6d, 32'h7c, 32'h07, 32'h7f, 32'h67};

  // model state: value as a plain integer, prescaler phase, scan position
  int m_p = 0, m_val = 0, m_r = 0, m_idx = 0;
  int d_idx = 0, d_val = 0;
  int m_wrap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic int digit_of(input int v, input int k);
    return (v / pow10(k)) % 10;
  endfunction

  function automatic int bcd_of(input int v);
    int r = 0;
    for (int k = 0; k < ND; k++) r = r | (digit_of(v, k) << (4 * k));
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_p = 0; m_val = 0; m_r = 0; m_idx = 0;
        d_idx = 0; d_val = 0; m_wrap = 0;
      end else begin
        d_idx  = m_idx;
        d_val  = m_val;
        m_wrap = 0;
        if (clear) begin
          m_p = 0; m_val = 0;
        end else if (enable) begin
          if (m_p == CLK_DIV - 1) begin
            m_p = 0;
            if (up_down) begin
              m_wrap = (m_val == MODULO - 1) ? 1 : 0;
              m_val  = (m_val + 1) % MODULO;
            end else begin
              m_wrap = (m_val == 0) ? 1 : 0;
              m_val  = (m_val + MODULO - 1) % MODULO;
            end
          end else begin
            m_p++;
          end
        end
        if (m_r == RD - 1) begin
          m_r = 0; m_idx = (m_idx + 1) % ND;
        end else begin
          m_r++;
        end
      end
    end
  end

  initial begin
    forever begin
      int seg_a, blank_b;
      @(negedge clk);
      seg_a   = seg_tab[digit_of(d_val, d_idx)];
      blank_b = (d_idx > 0 && d_val < pow10(d_idx)) ? 1 : 0;
      check("count_a", a_count, bcd_of(m_val));
      check("count_b", b_count, bcd_of(m_val));
      check("wrap_a",  a_wrap, m_wrap);
      check("wrap_b",  b_wrap, m_wrap);
      check("sel_a",   a_sel, (1 << d_idx));
      check("led_a",   a_led, seg_a);
      check("sel_b",   b_sel, (~(1 << d_idx)) & ((1 << ND) - 1));
      check("led_b",   b_led, (blank_b ? 0 : seg_a) ^ 32'h7f);
      check("oeb",     {a_oeb, b_oeb}, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, a_count, 8'h00);
    check({tag, "_wrap"},  a_wrap, 1'b0);
    check({tag, "_sel_a"}, a_sel, 2'b01);
    check({tag, "_led_a"}, a_led, 7'b0111111);
    check({tag, "_sel_b"}, b_sel, 2'b10);
    check({tag, "_led_b"}, b_led, 7'b1000000);
  endtask

  initial begin
    int found;
    step(2);
    check_reset_values("reset");

    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    step(40);
    check("up_10_ticks", a_count, 8'h10);
    step(356);
    check("up_to_99", a_count, 8'h99);
    step(4);
    check("up_wrap_count", a_count, 8'h00);
    check("up_wrap_pulse", a_wrap, 1'b1);
    step(1);
    check("up_wrap_single", a_wrap, 1'b0);

    up_down = 1'b0;
    step(3);
    check("down_wrap_count", a_count, 8'h99);
    check("down_wrap_pulse", a_wrap, 1'b1);
    step(4);
    check("down_98", a_count, 8'h98);

    step(2);
    enable = 1'b0;
    step(20);
    check("frozen", a_count, 8'h98);
    enable = 1'b1;
    step(1);
    check("resume_phase", a_count, 8'h98);
    step(1);
    check("resume_tick", a_count, 8'h97);

    step(240);
    check("down_to_37", a_count, 8'h37);
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_on_tick", a_count, 8'h00);
    check("clear_no_wrap", a_wrap, 1'b0);

    up_down = 1'b1;
    step(20);
    check("count_05", b_count, 8'h05);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (b_sel == 2'b01) found = 1; else step(1);
    end
    check("lz_find_digit1", found, 1);
    check("lz_blank_digit1", b_led, 7'b1111111);
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (b_sel == 2'b10) found = 1; else step(1);
    end
    check("lz_find_digit0", found, 1);
    check("lz_digit0_five", b_led, 7'b0010010);

    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      enable = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) up_down = ~up_down;
      clear = ($urandom_range(0, 99) == 0);
    end

    step(1);
    reset = 1'b0; enable = 1'b1; up_down = 1'b1; clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(12);
    check("pre_reset_count", a_count, 8'h03);
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    step(1);
    reset = 1'b0;
    step(4);
    check("after_reset_count", a_count, 8'h01);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
